// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signal bundle for dmem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ requesters,
// with bounded lock for RMW sequences. Define DMEM_ARB_CPU_PRIO_EN to give requester 0 priority.
module dmem_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic [IW:0]     pick;
  logic [IW-1:0]   gnt_idx;
  logic            hs;
  logic [NREQ-1:0] ready;

  logic            mem_en_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            tag_vld_p1, tag_vld_p2;
  logic [IW-1:0]   tag_idx_p1, tag_idx_p2;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Returns {found, index}: first set bit of v searching upward from ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int          c;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NREQ;
      if (v[c]) r = {1'b1, c[IW-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    pick  = '0;
    ready = '0;
    if (state_q == LOCKED) begin
      pick = {bus.req_valid[owner_q], owner_q};
    end else begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      if (bus.req_valid[0]) pick = {1'b1, {IW{1'b0}}};
      else pick = rr_pick(bus.req_valid & {{(NREQ-1){1'b1}}, 1'b0}, rr_q);
`else
      pick = rr_pick(bus.req_valid, rr_q);
`endif
    end
    if (pick[IW] && rst_n) ready[pick[IW-1:0]] = 1'b1;
  end

  assign gnt_idx = pick[IW-1:0];
  assign hs      = pick[IW] & rst_n;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (hs) begin
      if (state_q == ARB) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
        if (gnt_idx != '0) rr_d = wrap_inc(gnt_idx);
`else
        rr_d = wrap_inc(gnt_idx);
`endif
        if (bus.req_lock[gnt_idx] && MAX_LOCK > 1) begin
          state_d    = LOCKED;
          owner_d    = gnt_idx;
          lock_cnt_d = 4'd1;
        end
      // lock_cnt_q grants already done; this handshake is grant lock_cnt_q+1
      end else if (bus.req_lock[owner_q] && (int'(lock_cnt_q) + 1) < MAX_LOCK) begin
        lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
        state_d    = ARB;
        rr_d       = wrap_inc(owner_q);
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_q        <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_vld_p1  <= 1'b0;
      tag_idx_p1  <= '0;
      tag_vld_p2  <= 1'b0;
      tag_idx_p2  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      // p1: memory command issued, tag captured
      mem_en_q   <= hs;
      mem_we_q   <= hs & bus.req_we[gnt_idx];
      if (hs) begin
        mem_addr_q  <= bus.req_addr[gnt_idx*AW +: AW];
        mem_wdata_q <= bus.req_wdata[gnt_idx*DW +: DW];
      end
      tag_vld_p1 <= hs & ~bus.req_we[gnt_idx];
      tag_idx_p1 <= gnt_idx;
      // p2: memory sampling the command
      tag_vld_p2 <= tag_vld_p1;
      tag_idx_p2 <= tag_idx_p1;
      // response: read data returned to originator
      rsp_valid_q <= '0;
      if (tag_vld_p2) begin
        rsp_valid_q[tag_idx_p2] <= 1'b1;
        rsp_rdata_q             <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences, and random traffic
// checked against a transaction-level model with a behavioural SRAM.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int NREQ = 3, AW = 8, DW = 8, MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h10) return 8'hA5;
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Synchronous-read SRAM, preloaded during the first clock of reset
  logic [DW-1:0] sram [256];
  logic [DW-1:0] sram_rd = '0;
  logic          sram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
      sram_init_done <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      sram_rd <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_rd;

  typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
  typedef struct { logic [NREQ-1:0] v; logic [NREQ-1:0] lk; logic [NREQ-1:0] exp; } vec_t;

  logic [NREQ-1:0] drv_v, drv_we, drv_lk;
  logic [AW-1:0]   drv_addr [NREQ];
  logic [DW-1:0]   drv_wd   [NREQ];

  logic [DW-1:0] ref_mem [256];
  rsp_t          rq [$];
  int            m_rr, m_owner, m_cnt;
  bit            m_locked;
  bit            prev_hs, prev_we;
  logic [AW-1:0] prev_addr, last_addr;
  logic [DW-1:0] prev_wdata;
  int            cyc, tests, fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    prev_hs = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0; last_addr = '0;
    rq.delete();
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
`ifdef DMEM_ARB_CPU_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int c = (m_rr + k) % NREQ;
`ifdef DMEM_ARB_CPU_PRIO_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    prev_hs = (g >= 0);
    if (g < 0) return;
    prev_we = drv_we[g]; prev_addr = drv_addr[g]; prev_wdata = drv_wd[g];
    last_addr = drv_addr[g];
    if (drv_we[g]) ref_mem[drv_addr[g]] = drv_wd[g];
    else rq.push_back('{cyc + 3, g, ref_mem[drv_addr[g]]});
    if (!m_locked) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      if (g != 0) m_rr = (g + 1) % NREQ;
`else
      m_rr = (g + 1) % NREQ;
`endif
      if (drv_lk[g] && MAX_LOCK > 1) begin m_locked = 1; m_owner = g; m_cnt = 1; end
    end else begin
      m_cnt++;
      if (!drv_lk[g] || m_cnt >= MAX_LOCK) begin m_locked = 0; m_rr = (m_owner + 1) % NREQ; end
    end
    drv_v[g] = 1'b0;
  endtask

  task automatic apply_inputs();
    bus.req_valid = drv_v;
    bus.req_we    = drv_we;
    bus.req_lock  = drv_lk;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]  = drv_addr[i];
      bus.req_wdata[i*DW +: DW] = drv_wd[i];
    end
  endtask

  // One clock: check registered outputs, drive requests, check grant, advance model
  task automatic cycle(input bit chk, input logic [NREQ-1:0] exp_rdy);
    int g;
    @(negedge clk);
    check("mem_en", 32'(bus.mem_en), 32'(prev_hs));
    if (prev_hs) begin
      check("mem_we", 32'(bus.mem_we), 32'(prev_we));
      check("mem_addr", 32'(bus.mem_addr), 32'(prev_addr));
      if (prev_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(prev_wdata));
    end else begin
      check("mem_addr_hold", 32'(bus.mem_addr), 32'(last_addr));
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << rq[0].idx);
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(rq[0].data));
      void'(rq.pop_front());
    end else begin
      check("rsp_idle", 32'(bus.rsp_valid), 32'(0));
    end
    apply_inputs();
    #1;
    g = model_grant(drv_v);
    check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'(0) : (32'(1) << g));
    if (chk) check("req_ready_vec", 32'(bus.req_ready), 32'(exp_rdy));
    model_commit(g);
    cyc++;
  endtask

  task automatic idle(input int n);
    drv_v = '0;
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  initial begin
    vec_t tbl [$];
    int   pulses;
    logic [DW-1:0] got;

`ifdef DMEM_ARB_CPU_PRIO_EN
    for (int i = 0; i < 6; i++) tbl.push_back('{3'b111, 3'b000, 3'b001});
    tbl.push_back('{3'b110, 3'b000, 3'b010});
    tbl.push_back('{3'b110, 3'b000, 3'b100});
    tbl.push_back('{3'b110, 3'b000, 3'b010});
`else
    for (int i = 0; i < 6; i++) tbl.push_back('{3'b111, 3'b000, 3'(1 << (i % 3))});
`endif
    tbl.push_back('{3'b111, 3'b001, 3'b001});  // lock taken by req 0
    tbl.push_back('{3'b110, 3'b000, 3'b000});  // owner idle: others still blocked
    tbl.push_back('{3'b111, 3'b001, 3'b001});
    tbl.push_back('{3'b111, 3'b000, 3'b001});  // lock released
    tbl.push_back('{3'b110, 3'b000, 3'b010});
    tbl.push_back('{3'b110, 3'b000, 3'b100});
    for (int i = 0; i < 4; i++) tbl.push_back('{3'b111, 3'b001, 3'b001});
    tbl.push_back('{3'b110, 3'b000, 3'b010});  // forced release after MAX_LOCK grants

    tests = 0; fails = 0; cyc = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    drv_v = '1; drv_we = '0; drv_lk = '0;
    for (int i = 0; i < NREQ; i++) begin drv_addr[i] = 8'(8'h40 + i); drv_wd[i] = 8'(i); end
    apply_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    drv_v = '0;
    apply_inputs();
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      drv_v = tbl[k].v; drv_lk = tbl[k].lk; drv_we = '0;
      for (int i = 0; i < NREQ; i++) begin drv_addr[i] = 8'(8'h40 + i); drv_wd[i] = 8'($urandom); end
      cycle(1'b1, tbl[k].exp);
    end
    drv_lk = '0;
    idle(3);

    // Single read of preloaded 0xA5
    drv_v = 3'b010; drv_we = '0; drv_addr[1] = 8'h10;
    cycle(1'b1, 3'b010);
    pulses = 0; got = '0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (bus.rsp_valid[1]) begin pulses++; got = bus.rsp_rdata; end
    end
    check("single_read_pulses", 32'(pulses), 1);
    check("single_read_data", 32'(got), 32'hA5);

    // Write then read back-to-back
    drv_v = 3'b100; drv_we = 3'b100; drv_addr[2] = 8'h20; drv_wd[2] = 8'h3C;
    cycle(1'b1, 3'b100);
    drv_v = 3'b100; drv_we = 3'b000;
    cycle(1'b1, 3'b100);
    pulses = 0; got = '0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (bus.rsp_valid[2]) begin pulses++; got = bus.rsp_rdata; end
    end
    check("raw_pulses", 32'(pulses), 1);
    check("raw_data", 32'(got), 32'h3C);

    // Reset one cycle after a read handshake
    drv_v = 3'b010; drv_we = '0; drv_addr[1] = 8'h11;
    cycle(1'b1, 3'b010);
    @(negedge clk);
    check("midrst_mem_en_before", 32'(bus.mem_en), 1);
    drv_v = 3'b111;
    apply_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.req_ready), 0);
    check("midrst_mem_en", 32'(bus.mem_en), 0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    drv_v = '0;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(5);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (drv_v[i]) begin
          if ($urandom_range(0, 19) == 0) drv_v[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          drv_v[i]    = 1'b1;
          drv_we[i]   = ($urandom_range(0, 2) == 0);
          drv_lk[i]   = ($urandom_range(0, 3) == 0);
          drv_addr[i] = 8'($urandom_range(0, 15));
          drv_wd[i]   = 8'($urandom);
        end
      end
      cycle(1'b0, '0);
    end
    drv_lk = '0;
    idle(6);
    check("rsp_drained", 32'(rq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory between NREQ requesters: requester 0 is the CPU load path; the rest are vision DMA/pixel-fetch engines.
- Performs round-robin grant, one transaction per cycle, with an optional bounded lock for read-modify-write sequences.
- Drives the memory through registered outputs and returns read data to the originator in order.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- MAX_LOCK, 4, maximum consecutive locked grants before forced release (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep the grant after this transaction.
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data; same packing as req_addr.
- req_ready  out  NREQ  one-hot (or zero) grant; handshake = valid & ready.
- rsp_valid  out  NREQ  one-cycle pulse, read data for requester i.
- rsp_rdata  out  DW  read data, valid when any rsp_valid bit is set.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en is sampled.

Behaviour:
- Reset values: req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset state: state=ARB, rr pointer=0, lock count=0, pipeline tags cleared.
- req_ready is combinational from req_valid and registered state, and has at most one bit set.
- Requesters hold valid and payload stable until the handshake completes. Dropping valid before the handshake is allowed; nothing is issued for it.
- State ARB:
  - Grant the first valid requester searching from rr_ptr upward, wrapping modulo NREQ.
  - On a handshake by requester g: rr_ptr <= (g+1) mod NREQ.
  - If req_lock[g]=1 on the handshake, go to LOCKED with owner=g and lock_cnt=1.
- State LOCKED:
  - Only the owner may be granted. req_ready[owner]=req_valid[owner]; all other ready bits are 0, even if the owner is idle.
  - Owner handshake with lock=1 and lock_cnt<MAX_LOCK: stay in LOCKED, lock_cnt+1.
  - Owner handshake with lock=0, or with lock_cnt==MAX_LOCK: complete that transaction, then go to ARB with rr_ptr=(owner+1) mod NREQ.
  - rr_ptr does not move during the lock.
- Pipeline timing, for a handshake sampled at edge E0:
  - mem_* outputs are registered and asserted for the cycle after E0.
  - The memory samples them at E1; mem_rdata is valid in the following cycle.
  - For reads: at E2, rsp_valid[g]=1 and rsp_rdata=mem_rdata are registered and held for one cycle.
  - Writes produce no response.
  - With no handshake, mem_en=0 the next cycle; mem_addr and mem_wdata hold their last values.
- Throughput is one transaction per cycle. Responses return in issue order; read-after-write to the same address returns the new data.
- The originator tag (index plus read flag) travels through a 2-stage shift register alongside the access.
- Reset asserted mid-operation: in-flight tags are cleared and no rsp_valid is issued for them. The lock is released and state returns to ARB.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined: in ARB, requester 0 (CPU) wins whenever req_valid[0]=1, overriding round-robin. Round-robin applies only among requesters 1..NREQ-1, and a requester-0 grant does not move rr_ptr. An active LOCKED owner still excludes requester 0.
- Undefined: pure round-robin across all NREQ requesters, as described above.

Test Plan:
- Single read: memory preloaded with addr 0x10=0xA5; req 1 reads 0x10 -> req_ready[1] same cycle, mem_en/addr=0x10 next cycle, rsp_valid[1] with rsp_rdata=0xA5 two edges after the handshake.
- Round-robin: all 3 requesters hold valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; mem_en stays high back-to-back.
- Write then read: req 2 writes 0x3C to 0x20, then reads 0x20 in the next cycle -> rsp_rdata=0x3C, exactly one rsp_valid pulse.
- Lock: req 0 issues 3 transactions with lock=1,1,0 while reqs 1 and 2 are valid -> reqs 1 and 2 see ready=0 throughout, and req 1 is granted right after. With MAX_LOCK=4 and lock held at 1 continuously -> forced release after the 4th grant.
- Reset mid-flight: rst_n driven low one cycle after a read handshake -> all outputs go to 0 immediately and no rsp_valid appears after rst_n rises.
- With DMEM_ARB_CPU_PRIO_EN and all requesters valid -> req 0 is granted every cycle. Drop req_valid[0] -> reqs 1 and 2 alternate.
